// File: rtl/fsm_onehot_count_driver_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fsm_onehot_pkg
// Purpose  : Shared definitions for the 9-state one-hot pulse counter and its
//            transmit-side driver: state encoding, counter transition table
//            and count/one-hot conversions.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_onehot_pkg;

  localparam int MAX_COUNT = 8;

  typedef enum logic [MAX_COUNT:0] {
    S0 = 9'b0_0000_0001,
    S1 = 9'b0_0000_0010,
    S2 = 9'b0_0000_0100,
    S3 = 9'b0_0000_1000,
    S4 = 9'b0_0001_0000,
    S5 = 9'b0_0010_0000,
    S6 = 9'b0_0100_0000,
    S7 = 9'b0_1000_0000,
    S8 = 9'b1_0000_0000
  } state_t;

  // Steering controller state
  typedef enum logic {
    CTRL_IDLE  = 1'b0,
    CTRL_STEER = 1'b1
  } ctrl_t;

  // Counter transition table: in=1 advances (S8 saturates), in=0 holds
  // except at S8 where it wraps to S0. Anything not one-hot recovers to S0.
  function automatic state_t onehot_next(input state_t s, input logic in_bit);
    case (s)
      S0:      onehot_next = in_bit ? S1 : S0;
      S1:      onehot_next = in_bit ? S2 : S1;
      S2:      onehot_next = in_bit ? S3 : S2;
      S3:      onehot_next = in_bit ? S4 : S3;
      S4:      onehot_next = in_bit ? S5 : S4;
      S5:      onehot_next = in_bit ? S6 : S5;
      S6:      onehot_next = in_bit ? S7 : S6;
      S7:      onehot_next = in_bit ? S8 : S7;
      S8:      onehot_next = in_bit ? S8 : S0;
      default: onehot_next = S0;
    endcase
  endfunction

  function automatic logic [3:0] onehot_to_count(input state_t s);
    case (s)
      S0:      onehot_to_count = 4'd0;
      S1:      onehot_to_count = 4'd1;
      S2:      onehot_to_count = 4'd2;
      S3:      onehot_to_count = 4'd3;
      S4:      onehot_to_count = 4'd4;
      S5:      onehot_to_count = 4'd5;
      S6:      onehot_to_count = 4'd6;
      S7:      onehot_to_count = 4'd7;
      S8:      onehot_to_count = 4'd8;
      default: onehot_to_count = 4'd0;
    endcase
  endfunction

  function automatic state_t count_to_onehot(input logic [3:0] c);
    case (c)
      4'd0:    count_to_onehot = S0;
      4'd1:    count_to_onehot = S1;
      4'd2:    count_to_onehot = S2;
      4'd3:    count_to_onehot = S3;
      4'd4:    count_to_onehot = S4;
      4'd5:    count_to_onehot = S5;
      4'd6:    count_to_onehot = S6;
      4'd7:    count_to_onehot = S7;
      4'd8:    count_to_onehot = S8;
      default: count_to_onehot = S0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_onehot_count_driver_if.sv
`default_nettype none
// ============================================================================
// Interface : fsm_onehot_count_driver_if
// Purpose   : Valid/ready command channel carrying a target count to the
//             counter driver, plus the bad-command error pulse.
// Signals   : cmd_valid (m->s), cmd_count[CNT_W] (m->s),
//             cmd_ready (s->m), cmd_err (s->m)
// Revision  : 1.0 - initial release
// ============================================================================
interface fsm_onehot_count_driver_if #(
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_err;

  modport master (output cmd_valid, output cmd_count, input cmd_ready, input cmd_err);
  modport slave  (input cmd_valid, input cmd_count, output cmd_ready, output cmd_err);
endinterface
`default_nettype wire

// File: rtl/fsm_onehot_count_driver_mirror.sv
`default_nettype none
// ============================================================================
// Module   : fsm_onehot_mirror
// Purpose  : Cycle-exact one-hot copy of the downstream counter state, fed by
//            the same serial stream the counter sees.
// Ports    : clk, rst_n        - clock, async active-low reset
//            pulse_i           - serial stream driven to the counter
//            count_o           - binary value of the current mirror state
//            next_count_o      - binary value the mirror takes at next edge
// Revision : 1.0 - initial release
// ============================================================================
module fsm_onehot_mirror
  import fsm_onehot_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] next_count_o
);

  state_t state_q;
  state_t state_d;

  assign state_d = onehot_next(state_q, pulse_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign count_o      = CNT_W'(onehot_to_count(state_q));
  assign next_count_o = CNT_W'(onehot_to_count(state_d));

endmodule
`default_nettype wire

// File: rtl/fsm_onehot_count_driver.sv
`default_nettype none
// ============================================================================
// Module   : fsm_onehot_count_driver
// Purpose  : Accepts a target count and emits the serial stream that steers
//            the one-hot pulse counter to it along the shortest legal path.
// Ports    : clk, rst_n        - clock, async active-low reset
//            cmd (slave)       - cmd_valid/cmd_ready/cmd_count/cmd_err
//            pulse_out         - registered stream to the counter input
//            busy              - steering in progress
//            done              - one-cycle pulse, mirror reached the target
//            mirror_count      - binary value of the mirrored counter state
// Revision : 1.0 - initial release
// ============================================================================
module fsm_onehot_count_driver #(
  parameter int MAX_COUNT = fsm_onehot_pkg::MAX_COUNT,
  parameter int CNT_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fsm_onehot_count_driver_if.slave   cmd,
  output logic                       pulse_out,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           mirror_count
);
  import fsm_onehot_pkg::*;

  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] tgt_q;
  logic             pulse_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] next_count;

  // Next serial bit given mirror value m and target t. When parked, the
  // counter must see 1 at S8 (0 would wrap it) and 0 elsewhere. Moving down
  // is only possible via the S8 -> S0 wrap, so climb to S8 then drop once.
  function automatic logic step(input logic [CNT_W-1:0] m, input logic [CNT_W-1:0] t);
    if (m == t)     step = (m == CNT_W'(MAX_COUNT));
    else if (m < t) step = 1'b1;
    else            step = (m != CNT_W'(MAX_COUNT));
  endfunction

  fsm_onehot_mirror #(.CNT_W(CNT_W)) u_mirror (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_i      (pulse_q),
    .count_o      (mirror_count),
    .next_count_o (next_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_IDLE;
      tgt_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (ctrl_q)
        CTRL_IDLE: begin
          // Idle stream is the hold value, so the mirror never moves here
          // and next_count equals mirror_count.
          pulse_q <= step(next_count, next_count);
          if (cmd.cmd_valid) begin
            if (cmd.cmd_count > CNT_W'(MAX_COUNT)) begin
              err_q <= 1'b1;
            end else begin
              tgt_q   <= cmd.cmd_count;
              pulse_q <= step(mirror_count, cmd.cmd_count);
              if (cmd.cmd_count == mirror_count) begin
                done_q <= 1'b1;
              end else begin
                ctrl_q <= CTRL_STEER;
              end
            end
          end
        end
        CTRL_STEER: begin
          pulse_q <= step(next_count, tgt_q);
          if (next_count == tgt_q) begin
            ctrl_q <= CTRL_IDLE;
            done_q <= 1'b1;
          end
        end
        default: ctrl_q <= CTRL_IDLE;
      endcase
    end
  end

  assign busy          = (ctrl_q == CTRL_STEER);
  assign cmd.cmd_ready = ~busy;
  assign cmd.cmd_err   = err_q;
  assign pulse_out     = pulse_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: doc/fsm_onehot_count_driver.md
Name: fsm_onehot_count_driver

Overview:
- Transmit-side companion to the team's 9-state one-hot pulse counter (states S0..S8, output count 0..8).
- The counter's rules:
  - in=1 advances one state, and S8 holds on in=1.
  - in=0 holds in S0..S7, and S8 wraps to S0 on in=0.
- This block accepts a target count over a valid/ready command interface and generates the serial `in` stream that steers the counter to that target by the shortest legal path.
- It keeps a cycle-exact one-hot mirror of the counter state, so it needs no feedback from the counter.
- It sits upstream of the counter, sharing its clock and reset event.

Parameters:
- MAX_COUNT, 8: highest counter value; the one-hot mirror width is MAX_COUNT+1 (9).
- CNT_W, 4: width of count fields; must satisfy 2**CNT_W > MAX_COUNT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle (busy=0).
- cmd_count  in  CNT_W  target count; legal range 0..MAX_COUNT.
- cmd_err  out  1  one-cycle pulse: command carried cmd_count>MAX_COUNT.
- pulse_out  out  1  registered serial stream to the counter's `in`.
- busy  out  1  steering in progress.
- done  out  1  one-cycle pulse: mirror has reached the target.
- mirror_count  out  CNT_W  binary value of the mirror state.

Behaviour:
- Reset (async, rst_n=0) forces:
  - mirror=S0, tgt=0, busy=0, done=0, cmd_err=0, pulse_out=0.
  - mirror_count=0 and cmd_ready=1.
- Reset mid-steer aborts immediately. No resume; the counter is expected to reset on the same event.
- Mirror update, every edge: mirror <= f(mirror, pulse_out), where f is exactly the counter transition table. Invalid one-hot values go to S0.
- step(m,t), the next pulse_out value:
  - m==t: hold value, 1 if m==S8 else 0. A 0 at S8 would wrap the counter.
  - m<t: 1.
  - m>t: 1 if m!=S8, else 0 (the wrap cycle).
- Accept: edge with cmd_valid & cmd_ready.
  - If cmd_count>MAX_COUNT: cmd_err=1 for one cycle. Nothing else changes and pulse_out keeps its hold value.
  - Otherwise, with c = mirror_count before the edge:
    - tgt <= cmd_count.
    - pulse_out <= step(c, cmd_count).
    - If cmd_count==c: busy stays 0 and done=1 next cycle.
    - Else: busy <= 1.
- Busy edge: mn = f(mirror, pulse_out).
  - pulse_out <= step(mn, tgt).
  - If mn==tgt: busy <= 0 and done <= 1 for one cycle.
- Idle: pulse_out = step(mirror, mirror), i.e. 1 only while parked at S8.
- Drive length N, in edges from accept to the edge that raises done:
  - t>c: N = t-c, all ones.
  - t<c: N = (MAX_COUNT-c) ones + one zero + t ones = MAX_COUNT-c+1+t.
  - t==c: N = 0, and done is seen one cycle after accept.
- Command handling:
  - cmd_valid while busy: ignored, no state change. It is held until ready.
  - Commands are accepted back-to-back: ready returns in the same cycle done is high.
- done, cmd_err and busy are registered. pulse_out has no combinational path from inputs.

Decomposition:
- Package fsm_onehot_pkg contains:
  - the one-hot state_t enum S0..S8;
  - function onehot_next(state_t, logic in), the counter table;
  - function onehot_to_count(state_t) and function count_to_onehot;
  - constant MAX_COUNT.
- The counter, this block and the bench share the package, so the mirror model is single-sourced.
- One sub-module, fsm_onehot_mirror: the state register plus onehot_next plus mirror_count decode.
- Steering control (step logic, busy/done/err) lives in the top.

Test Plan:
- Reset, then cmd_count=5 from S0:
  - pulse_out=1 for exactly 5 cycles, then 0.
  - done is high one cycle later, mirror_count=5.
  - An instantiated counter outputs 4'b0101.
- From 3, cmd_count=1:
  - pulse_out sequence 1,1,1,1,1,0,1, then 0.
  - N=7; mirror passes 8 then 0; done has mirror_count=1.
- cmd_count=8 from 0:
  - 8 ones, then pulse_out stays 1 while idle.
  - The counter holds 4'b1000 for 20 idle cycles.
  - Then cmd_count=0: a single 0 pulse, done with count 0.
- cmd_count=4 with mirror at 4:
  - No pulse_out activity; done the next cycle.
  - Then cmd_count=12: cmd_err pulse, no motion, mirror_count still 4.
- cmd_valid held high during a 6-cycle steer with a different count:
  - It is not accepted until done.
  - The second command is accepted the cycle done=1, and the back-to-back targets are both reached.
- rst_n low in the middle of a 0→7 steer (after 3 ones):
  - All outputs go to reset values immediately.
  - After release, cmd_count=2 produces exactly 2 ones.
